// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and its neighbours.
package mem_arb_pkg;

  // Width of the checker starvation counter (saturates at its all-ones value).
  localparam int STARVE_W = 4;

  // Default dm geometry, shared with the data memory itself.
  localparam int DM_ADDR_W = 7;
  localparam int DM_DATA_W = 32;

  // Which requester owns the read whose data returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_CHK  = 2'd2
  } owner_e;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU, checker and dm-pin signals around the dm port arbiter.
// The arbiter uses the slave view; requesters and the memory use master.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);

  // CPU MEM-stage port
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // Checker reference-read port
  logic              chk_req;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_gnt;
  logic              chk_rvalid;
  logic [DATA_W-1:0] chk_rdata;

  // Data-memory pins
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  chk_req, chk_addr,
    output chk_gnt, chk_rvalid, chk_rdata,
    output dm_addr, dm_rd, dm_wr, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output chk_req, chk_addr,
    input  chk_gnt, chk_rvalid, chk_rdata,
    input  dm_addr, dm_rd, dm_wr, dm_wdata,
    output dm_rdata
  );

endinterface

// File: rtl/dm_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the checker asked and lost.
// force_chk tells the arbiter to hand the next contested slot to the checker.
module starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_chk
);

  localparam logic [STARVE_W-1:0] CNT_MAX = '1;
  localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt;

  // Count lost checker cycles; a grant clears, otherwise hold, saturate at max.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_chk = (cnt >= LIMIT_V);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single dm port between the CPU MEM stage (default winner) and
// the checker's reference reads, with aging so the checker is never starved.
// Read data comes back one cycle after the grant and is steered by rd_owner.
module dm_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DM_ADDR_W,
  parameter int DATA_W       = DM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  dm_port_arbiter_if.slave    bus,
  output logic [15:0]         conflict_cnt
);

  logic              force_chk;
  logic              cpu_win;
  logic              chk_win;
  logic              both_req;
  logic [ADDR_W-1:0] addr_mux;
  logic              rd_mux;
  logic              wr_mux;
  logic [DATA_W-1:0] wdata_mux;
  owner_e            next_owner;
  owner_e            rd_owner;

  assign both_req = bus.cpu_req & bus.chk_req;

  // Aging counter: checker lost this cycle -> count up; checker granted -> clear.
  starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc       (bus.chk_req & ~chk_win),
    .clr       (chk_win),
    .force_chk (force_chk)
  );

  // Winner selection and dm pin mux; zero-latency, driven from live requests.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch can be inferred.
  always_comb begin
    cpu_win    = bus.cpu_req & ~(bus.chk_req & force_chk);
    chk_win    = bus.chk_req & ~cpu_win;
    addr_mux   = '0;
    rd_mux     = 1'b0;
    wr_mux     = 1'b0;
    wdata_mux  = '0;
    next_owner = OWN_NONE;
    if (cpu_win) begin
      addr_mux   = bus.cpu_addr;
      rd_mux     = ~bus.cpu_wr;
      wr_mux     = bus.cpu_wr;
      wdata_mux  = bus.cpu_wdata;
      next_owner = bus.cpu_wr ? OWN_NONE : OWN_CPU;
    end else if (chk_win) begin
      addr_mux   = bus.chk_addr;
      rd_mux     = 1'b1;
      next_owner = OWN_CHK;
    end
  end

  assign bus.cpu_gnt   = cpu_win;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_win;
  assign bus.chk_gnt   = chk_win;
  assign bus.dm_addr   = addr_mux;
  assign bus.dm_rd     = rd_mux;
  assign bus.dm_wr     = wr_mux;
  assign bus.dm_wdata  = wdata_mux;

  // Remember who issued the read now in flight; reset drops any such read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= next_owner;
    end
  end

  // Steer the returning dm word to its owner; the other side sees zero.
  assign bus.cpu_rvalid = (rd_owner == OWN_CPU);
  assign bus.chk_rvalid = (rd_owner == OWN_CHK);
  assign bus.cpu_rdata  = (rd_owner == OWN_CPU) ? bus.dm_rdata : '0;
  assign bus.chk_rdata  = (rd_owner == OWN_CHK) ? bus.dm_rdata : '0;

  // Count cycles with both requests asserted, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (both_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a one-cycle-latency dm model.
// Inputs change on negedge; combinational outputs are checked 1ns later,
// registered outputs 1ns after the posedge.
module tb_dm_port_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic        clk;
  logic        reset;
  logic [15:0] conflict_cnt;

  int total;
  int bad;

  dm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write lands at the edge, read data appears after the edge.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] dm_q;
  always @(posedge clk) begin
    if (bus.dm_wr) mem[bus.dm_addr] <= bus.dm_wdata;
    if (bus.dm_rd) dm_q <= mem[bus.dm_addr];
  end
  assign bus.dm_rdata = dm_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.chk_req   = 1'b0;
    bus.chk_addr  = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst_chk_rvalid", 32'(bus.chk_rvalid), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_chk_rdata", bus.chk_rdata, 32'd0);
    check("rst_conflict", 32'(conflict_cnt), 32'd0);
    check("rst_dm_rd", 32'(bus.dm_rd), 32'd0);
    check("rst_dm_wr", 32'(bus.dm_wr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ---- CPU only: store 0xDEADBEEF to 5, then load 5 ----
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 7'd5; bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    check("st_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("st_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("st_dm_wr", 32'(bus.dm_wr), 32'd1);
    check("st_dm_rd", 32'(bus.dm_rd), 32'd0);
    check("st_dm_addr", 32'(bus.dm_addr), 32'd5);
    check("st_dm_wdata", bus.dm_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("st_no_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("st_no_chk_rvalid", 32'(bus.chk_rvalid), 32'd0);
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_wdata = '0;
    #1;
    check("ld_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("ld_dm_rd", 32'(bus.dm_rd), 32'd1);
    check("ld_dm_wdata", bus.dm_wdata, 32'd0);
    @(posedge clk); #1;
    check("ld_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("ld_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("ld_chk_rvalid", 32'(bus.chk_rvalid), 32'd0);
    check("ld_chk_rdata", bus.chk_rdata, 32'd0);

    // ---- checker only: read 5 ----
    @(negedge clk);
    idle_inputs();
    bus.chk_req = 1'b1; bus.chk_addr = 7'd5;
    #1;
    check("chk_gnt", 32'(bus.chk_gnt), 32'd1);
    check("chk_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("chk_dm_rd", 32'(bus.dm_rd), 32'd1);
    check("chk_dm_addr", 32'(bus.dm_addr), 32'd5);
    @(posedge clk); #1;
    check("chk_rvalid", 32'(bus.chk_rvalid), 32'd1);
    check("chk_rdata", bus.chk_rdata, 32'hDEADBEEF);
    check("chk_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    // ---- contention for 10 cycles: checker wins cycles 5 and 10 ----
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 7'd5;
    bus.chk_req = 1'b1; bus.chk_addr = 7'd5;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      check($sformatf("cont%0d_chk_gnt", i), 32'(bus.chk_gnt), (i == 5 || i == 10) ? 32'd1 : 32'd0);
      check($sformatf("cont%0d_cpu_gnt", i), 32'(bus.cpu_gnt), (i == 5 || i == 10) ? 32'd0 : 32'd1);
      check($sformatf("cont%0d_stall", i), 32'(bus.cpu_stall), (i == 5 || i == 10) ? 32'd1 : 32'd0);
      @(posedge clk);
    end
    #1;
    check("cont_conflict_cnt", 32'(conflict_cnt), 32'd10);
    check("cont_last_chk_rvalid", 32'(bus.chk_rvalid), 32'd1);

    // ---- back-to-back: prime 1 and 2, CPU load 1 then checker load 2 ----
    @(negedge clk);
    idle_inputs();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 7'd1; bus.cpu_wdata = 32'h1111_1111;
    @(negedge clk);
    bus.cpu_addr = 7'd2; bus.cpu_wdata = 32'h2222_2222;
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_addr = 7'd1; bus.cpu_wdata = '0;
    #1;
    check("b2b_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    @(negedge clk);
    idle_inputs();
    bus.chk_req = 1'b1; bus.chk_addr = 7'd2;
    #1;
    check("b2b_chk_gnt", 32'(bus.chk_gnt), 32'd1);
    check("b2b_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("b2b_cpu_rdata", bus.cpu_rdata, 32'h1111_1111);
    @(posedge clk); #1;
    check("b2b_chk_rvalid", 32'(bus.chk_rvalid), 32'd1);
    check("b2b_chk_rdata", bus.chk_rdata, 32'h2222_2222);
    check("b2b_cpu_rvalid_off", 32'(bus.cpu_rvalid), 32'd0);

    // ---- store then checker read of the same word ----
    @(negedge clk);
    idle_inputs();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 7'd7; bus.cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    idle_inputs();
    bus.chk_req = 1'b1; bus.chk_addr = 7'd7;
    #1;
    check("swr_chk_gnt", 32'(bus.chk_gnt), 32'd1);
    @(posedge clk); #1;
    check("swr_chk_rvalid", 32'(bus.chk_rvalid), 32'd1);
    check("swr_chk_rdata", bus.chk_rdata, 32'h1234_5678);

    // ---- reset mid-read ----
    @(negedge clk);
    idle_inputs();
    bus.cpu_req = 1'b1; bus.cpu_addr = 7'd1;
    bus.chk_req = 1'b1; bus.chk_addr = 7'd7;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    check("rmr_chk_gnt", 32'(bus.chk_gnt), 32'd1);
    check("rmr_conflict_pre", 32'(conflict_cnt), 32'd11);
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rmr_chk_rvalid_async", 32'(bus.chk_rvalid), 32'd0);
    check("rmr_conflict_zero", 32'(conflict_cnt), 32'd0);
    check("rmr_starve_zero", 32'(dut.u_starve.cnt), 32'd0);
    @(posedge clk); #1;
    check("rmr_chk_rvalid_edge", 32'(bus.chk_rvalid), 32'd0);
    check("rmr_chk_rdata_edge", bus.chk_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rmr_no_late_rvalid", 32'(bus.chk_rvalid), 32'd0);
    @(negedge clk);
    bus.chk_req = 1'b1; bus.chk_addr = 7'd7;
    #1;
    check("post_rst_chk_gnt", 32'(bus.chk_gnt), 32'd1);
    @(posedge clk); #1;
    check("post_rst_chk_rvalid", 32'(bus.chk_rvalid), 32'd1);
    check("post_rst_chk_rdata", bus.chk_rdata, 32'h1234_5678);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("final_idle_rvalid", 32'(bus.chk_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
